runner_ctrl: RTL and testbench

- Parametrised game-loop controller: derives per-frame update pulses from painter completion, runs the game state machine, ramps speed and gates obstacle generation.
- Adds a PAUSED state and a post-crash restart lockout, both new.
- Sits between the input debouncers and the trex/horizon/distance_meter instances; its outputs drive their update, timer, speed, start, restart and has_obstacles inputs.

---
 rtl/runner_ctrl_if.sv | 28 ++
 rtl/runner_ctrl.sv | 175 +++++++++++++++++
 tb/tb_runner_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/runner_ctrl_if.sv
// Signal bundle between the game-loop controller and its surroundings
// (debounced keys, painter, collision logic and the sprite/horizon consumers).
interface runner_ctrl_if #(
    parameter int unsigned TIMER_W = 6,
    parameter int unsigned SPEED_W = 15
);
    logic               painter_finished;
    logic               jumping;
    logic               pause_req;
    logic               crash;
    logic               update;
    logic [TIMER_W-1:0] timer;
    logic [SPEED_W-1:0] speed;
    logic               start;
    logic               restart;
    logic               has_obstacles;
    logic [2:0]         state;

    modport master (
        output painter_finished, jumping, pause_req, crash,
        input  update, timer, speed, start, restart, has_obstacles, state
    );

    modport slave (
        input  painter_finished, jumping, pause_req, crash,
        output update, timer, speed, start, restart, has_obstacles, state
    );
endinterface

// File: rtl/runner_ctrl.sv
// Game-loop controller: frame update pulses from painter completion, game FSM with
// pause and post-crash lockout, speed ramp and obstacle gating.
module runner_ctrl #(
    parameter int unsigned FPS            = 60,
    parameter int unsigned TIMER_W        = 6,
    parameter int unsigned SPEED_W        = 15,
    parameter int unsigned SPEED_INIT     = 6144,
    parameter int unsigned SPEED_MAX      = 13312,
    parameter int unsigned ACCEL          = 1,
    parameter int unsigned CLEAR_FRAMES   = 180,
    parameter int unsigned CLEAR_W        = 8,
    parameter int unsigned LOCKOUT_FRAMES = 30,
    parameter int unsigned PAUSE_ENABLE   = 1
) (
    input logic          clk,
    input logic          rst,
    runner_ctrl_if.slave bus
);

    if (FPS < 1 || FPS > (1 << TIMER_W)) begin : g_bad_fps
        $error("runner_ctrl: FPS must be in 1..2**TIMER_W");
    end
    if (SPEED_INIT > SPEED_MAX) begin : g_bad_init
        $error("runner_ctrl: SPEED_INIT must not exceed SPEED_MAX");
    end
    if (SPEED_MAX >= (1 << SPEED_W)) begin : g_bad_max
        $error("runner_ctrl: SPEED_MAX must fit in SPEED_W bits");
    end
    if (CLEAR_FRAMES >= (1 << CLEAR_W)) begin : g_bad_clear
        $error("runner_ctrl: CLEAR_FRAMES must fit in CLEAR_W bits");
    end

    localparam int unsigned LockW = (LOCKOUT_FRAMES > 1) ? $clog2(LOCKOUT_FRAMES + 1) : 1;

    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(FPS - 1);
    localparam logic [SPEED_W-1:0] SpeedInit = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W:0]   SpeedMaxW = (SPEED_W + 1)'(SPEED_MAX);
    localparam logic [SPEED_W:0]   AccelW    = (SPEED_W + 1)'(ACCEL);
    localparam logic [CLEAR_W-1:0] ClearTgt  = CLEAR_W'(CLEAR_FRAMES);
    localparam logic [LockW-1:0]   LockInit  = LockW'(LOCKOUT_FRAMES);
    localparam bit                 PauseOn   = (PAUSE_ENABLE != 0);

    typedef enum logic [2:0] {
        StWaiting    = 3'd0,
        StRunning    = 3'd1,
        StPaused     = 3'd2,
        StCrashed    = 3'd3,
        StRestarting = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               update_q, update_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               start_q, start_d;
    logic               has_obs_q, has_obs_d;
    logic [CLEAR_W-1:0] clear_q, clear_d;
    logic [LockW-1:0]   lock_q, lock_d;
    logic               pf_last_q, jump_last_q, pause_last_q;

    logic               pf_rise, jump_rise, pause_rise;
    logic [SPEED_W:0]   speed_sum;
    logic [SPEED_W-1:0] speed_step;
    logic [CLEAR_W-1:0] clear_inc;

    assign pf_rise    = bus.painter_finished & ~pf_last_q;
    assign jump_rise  = bus.jumping & ~jump_last_q;
    assign pause_rise = bus.pause_req & ~pause_last_q;

    // One extra bit keeps the ramp from wrapping before the ceiling clamp.
    assign speed_sum  = {1'b0, speed_q} + AccelW;
    assign speed_step = (speed_sum > SpeedMaxW) ? SpeedMaxW[SPEED_W-1:0]
                                                : speed_sum[SPEED_W-1:0];
    assign clear_inc  = (clear_q == '1) ? clear_q : clear_q + CLEAR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StWaiting;
            update_q     <= 1'b0;
            timer_q      <= '0;
            speed_q      <= '0;
            start_q      <= 1'b0;
            has_obs_q    <= 1'b0;
            clear_q      <= '0;
            lock_q       <= '0;
            pf_last_q    <= 1'b0;
            jump_last_q  <= 1'b0;
            pause_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            update_q     <= update_d;
            timer_q      <= timer_d;
            speed_q      <= speed_d;
            start_q      <= start_d;
            has_obs_q    <= has_obs_d;
            clear_q      <= clear_d;
            lock_q       <= lock_d;
            pf_last_q    <= bus.painter_finished;
            jump_last_q  <= bus.jumping;
            pause_last_q <= bus.pause_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        update_d  = pf_rise;
        timer_d   = timer_q;
        speed_d   = speed_q;
        start_d   = start_q;
        has_obs_d = has_obs_q;
        clear_d   = clear_q;
        lock_d    = lock_q;

        if (pf_rise) begin
            timer_d = (timer_q == TimerLast) ? '0 : timer_q + TIMER_W'(1);
        end

        unique case (state_q)
            StWaiting: begin
                if (update_q && bus.jumping) begin
                    state_d = StRunning;
                    start_d = 1'b1;
                    speed_d = SpeedInit;
                    clear_d = '0;
                end
            end
            StRunning: begin
                // Crash wins over pause, and a pause swallows the step of its cycle.
                if (bus.crash) begin
                    state_d = StCrashed;
                    lock_d  = LockInit;
                end else if (pause_rise && PauseOn) begin
                    state_d = StPaused;
                end else if (update_q) begin
                    clear_d = clear_inc;
                    speed_d = speed_step;
                    if (clear_inc >= ClearTgt) begin
                        has_obs_d = 1'b1;
                    end
                end
            end
            StPaused: begin
                if (pause_rise) begin
                    state_d = StRunning;
                end
            end
            StCrashed: begin
                if (jump_rise && lock_q == '0) begin
                    state_d   = StRestarting;
                    start_d   = 1'b0;
                    speed_d   = '0;
                    clear_d   = '0;
                    has_obs_d = 1'b0;
                end else if (update_q && lock_q != '0) begin
                    lock_d = lock_q - LockW'(1);
                end
            end
            StRestarting: begin
                if (!bus.jumping) begin
                    state_d = StWaiting;
                end
            end
            default: state_d = StWaiting;
        endcase
    end

    assign bus.update        = update_q;
    assign bus.timer         = timer_q;
    assign bus.speed         = speed_q;
    assign bus.start         = start_q;
    assign bus.restart       = (state_q == StRestarting);
    assign bus.has_obstacles = has_obs_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_runner_ctrl.sv
// Bench for runner_ctrl: directed game walk-through plus random stimulus, with a
// cycle-level behavioural model of the game rules checked after every clock edge.
module tb_runner_ctrl;
    localparam int FPS          = 60;
    localparam int SPEED_INIT   = 6144;
    localparam int SPEED_MAX    = 13312;
    localparam int ACCEL        = 1;
    localparam int CLEAR_FRAMES = 180;
    localparam int CLEAR_SAT    = 255;
    localparam int LOCKOUT      = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    runner_ctrl_if #(.TIMER_W(6), .SPEED_W(15)) bus1 ();
    runner_ctrl_if #(.TIMER_W(6), .SPEED_W(15)) bus2 ();

    runner_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    runner_ctrl #(
        .SPEED_INIT (13310),
        .ACCEL      (4)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit c_pf, c_j, c_pz, c_c;

    // Model of the game: state numbers as the outputs report them.
    int m_state, m_timer, m_speed, m_clear, m_lock;
    bit m_update, m_start, m_has, m_pf_l, m_j_l, m_pz_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pfr, jr, pzr, upd;
        if (!rst) begin
            m_state = 0; m_timer = 0; m_speed = 0; m_clear = 0; m_lock = 0;
            m_update = 0; m_start = 0; m_has = 0;
            m_pf_l = 0; m_j_l = 0; m_pz_l = 0;
            return;
        end
        pfr = c_pf && !m_pf_l;
        jr  = c_j && !m_j_l;
        pzr = c_pz && !m_pz_l;
        upd = m_update;
        m_update = pfr;
        if (pfr) m_timer = (m_timer + 1) % FPS;
        case (m_state)
            0: if (upd && c_j) begin
                m_state = 1; m_start = 1; m_speed = SPEED_INIT; m_clear = 0;
            end
            1: if (c_c) begin
                m_state = 3; m_lock = LOCKOUT;
            end else if (pzr) begin
                m_state = 2;
            end else if (upd) begin
                m_clear = (m_clear < CLEAR_SAT) ? m_clear + 1 : CLEAR_SAT;
                if (m_clear >= CLEAR_FRAMES) m_has = 1;
                m_speed = (m_speed + ACCEL > SPEED_MAX) ? SPEED_MAX : m_speed + ACCEL;
            end
            2: if (pzr) m_state = 1;
            3: if (jr && m_lock == 0) begin
                m_state = 4; m_start = 0; m_speed = 0; m_clear = 0; m_has = 0;
            end else if (upd && m_lock > 0) begin
                m_lock = m_lock - 1;
            end
            4: if (!c_j) m_state = 0;
            default: ;
        endcase
        m_pf_l = c_pf; m_j_l = c_j; m_pz_l = c_pz;
    endtask

    task automatic compare_model();
        check("m_update",  bus1.update,        m_update);
        check("m_timer",   bus1.timer,         m_timer);
        check("m_speed",   bus1.speed,         m_speed);
        check("m_start",   bus1.start,         m_start);
        check("m_restart", bus1.restart,       (m_state == 4));
        check("m_has_obs", bus1.has_obstacles, m_has);
        check("m_state",   bus1.state,         m_state);
    endtask

    task automatic step(input bit pf);
        c_pf = pf;
        bus1.painter_finished = c_pf; bus1.jumping = c_j; bus1.pause_req = c_pz; bus1.crash = c_c;
        bus2.painter_finished = c_pf; bus2.jumping = c_j; bus2.pause_req = c_pz; bus2.crash = c_c;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // One painter rise; the FSM sees update during the second cycle.
    task automatic frame();
        step(1'b1);
        step(1'b0);
    endtask

    initial begin
        int pulses;
        int run;
        int t0;

        // Reset with toggling inputs
        c_pf = 1; c_j = 1; c_pz = 1; c_c = 1;
        step(1'b1);
        check("rst_state", bus1.state, 0);
        check("rst_speed", bus1.speed, 0);
        check("rst_start", bus1.start, 0);
        c_j = 0; c_pz = 0;
        step(1'b0);
        check("rst_update", bus1.update, 0);
        check("rst_timer", bus1.timer, 0);
        rst = 1; c_c = 0;
        step(1'b0);

        // Painter held high: a single update pulse
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            if (i == 0) check("pulse_first", bus1.update, 1);
            pulses += int'(bus1.update);
        end
        check("one_pulse", pulses, 1);
        check("timer_one", bus1.timer, 1);
        step(1'b0);

        for (int i = 0; i < 59; i++) frame();
        check("timer_wrap", bus1.timer, 0);
        frame();
        check("timer_after_wrap", bus1.timer, 1);

        // Jump during update starts the game
        c_j = 1;
        frame();
        c_j = 0;
        check("start_state", bus1.state, 1);
        check("start_flag", bus1.start, 1);
        check("start_speed", bus1.speed, SPEED_INIT);
        check("dut2_init", bus2.speed, 13310);
        frame();
        run = 1;
        check("speed_first", bus1.speed, SPEED_INIT + 1);
        check("dut2_clamp", bus2.speed, SPEED_MAX);
        frame();
        run = 2;
        check("dut2_hold", bus2.speed, SPEED_MAX);
        while (run < 56) begin
            frame();
            run++;
        end
        check("speed_6200", bus1.speed, 6200);

        // Pause
        c_pz = 1;
        step(1'b0);
        check("paused", bus1.state, 2);
        t0 = int'(bus1.timer);
        for (int i = 0; i < 50; i++) frame();
        check("pause_speed", bus1.speed, 6200);
        check("pause_timer", bus1.timer, (t0 + 50) % FPS);
        c_c = 1;
        step(1'b0);
        check("pause_crash", bus1.state, 2);
        c_c = 0; c_pz = 0;
        step(1'b0);
        c_pz = 1;
        step(1'b0);
        check("resumed", bus1.state, 1);
        c_pz = 0;
        frame();
        run++;
        check("resume_speed", bus1.speed, 6201);

        while (run < CLEAR_FRAMES) begin
            frame();
            run++;
            if (run == 100) check("speed_6244", bus1.speed, 6244);
            if (run == CLEAR_FRAMES - 1) check("obs_179", bus1.has_obstacles, 0);
            if (run == CLEAR_FRAMES) check("obs_180", bus1.has_obstacles, 1);
        end

        // Crash and lockout
        c_c = 1;
        step(1'b0);
        c_c = 0;
        check("crashed", bus1.state, 3);
        for (int i = 0; i < 10; i++) frame();
        check("crash_speed", bus1.speed, SPEED_INIT + CLEAR_FRAMES);
        c_j = 1;
        step(1'b0);
        check("jump_locked", bus1.state, 3);
        c_j = 0;
        step(1'b0);
        for (int i = 0; i < 20; i++) frame();
        c_j = 1;
        step(1'b0);
        check("restarting", bus1.state, 4);
        check("restart_flag", bus1.restart, 1);
        check("restart_speed", bus1.speed, 0);
        check("restart_obs", bus1.has_obstacles, 0);
        for (int i = 0; i < 5; i++) step(1'b0);
        check("restart_held", bus1.state, 4);
        c_j = 0;
        step(1'b0);
        check("back_waiting", bus1.state, 0);
        check("restart_off", bus1.restart, 0);

        // Crash, pause rise and update in the same cycle
        c_j = 1;
        frame();
        c_j = 0;
        check("restart_game", bus1.state, 1);
        frame();
        frame();
        step(1'b1);
        c_c = 1; c_pz = 1;
        step(1'b0);
        c_c = 0; c_pz = 0;
        check("triple_state", bus1.state, 3);
        check("triple_speed", bus1.speed, SPEED_INIT + 2);
        for (int i = 0; i < LOCKOUT; i++) frame();
        c_j = 1;
        step(1'b0);
        check("restart2", bus1.state, 4);
        rst = 0;
        step(1'b0);
        check("rst_mid_state", bus1.state, 0);
        check("rst_mid_restart", bus1.restart, 0);
        rst = 1; c_j = 0;
        step(1'b0);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            c_j  = ($urandom_range(0, 3) == 0);
            c_pz = ($urandom_range(0, 15) == 0);
            c_c  = ($urandom_range(0, 299) == 0);
            rst  = ($urandom_range(0, 999) != 0);
            step(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
